cmd_receiver: RTL and testbench

CMD_RECEIVER -- requirements
Module: cmd_receiver

---
 rtl/cmd_receiver.sv | 171 +++++++++++++++++
 tb/tb_cmd_receiver.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cmd_receiver.sv
// cmd_receiver: parses ASCII command lines ("<letter>[digits]<CR|LF>")
// from a serial byte stream and applies motor/datalog/reset side effects.
//
// Ports:
//   clk          system clock, all state on posedge
//   rst          asynchronous active-low reset
//   rx_data      received byte, valid when new_rx_data=1
//   new_rx_data  one-cycle byte strobe
//   cmd_valid    one-cycle pulse when a line completes
//   cmd_char     letter of last completed line (0x00 if none)
//   cmd_arg      decimal argument of last line (0 on error)
//   cmd_has_arg  last line carried at least one digit
//   cmd_err      last line malformed (qualified by cmd_valid)
//   motor_arm    motor armed state
//   data_log     datalog enable state
//   soft_rst     one-cycle board reset request
//   err_cnt      saturating count of malformed lines
module cmd_receiver #(
   parameter int MAX_DIGITS = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        new_rx_data,
   output logic        cmd_valid,
   output logic [7:0]  cmd_char,
   output logic [15:0] cmd_arg,
   output logic        cmd_has_arg,
   output logic        cmd_err,
   output logic        motor_arm,
   output logic        data_log,
   output logic        soft_rst,
   output logic [7:0]  err_cnt
);

   localparam int CW = $clog2(MAX_DIGITS + 1);
   localparam logic [CW-1:0] MAXD = CW'(MAX_DIGITS);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARG   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   state_t         r_state;
   logic [7:0]     r_letter;
   logic [15:0]    r_acc;
   logic [CW-1:0]  r_cnt;

   logic        w_is_digit;
   logic        w_is_lower;
   logic        w_is_term;
   logic        w_is_space;
   logic [3:0]  w_digit;
   logic [16:0] w_mul;
   logic [16:0] w_sum;
   logic        w_ovf;
   logic        w_has;
   logic        w_bad;
   logic        w_done;
   logic        w_err;

   assign w_is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
   assign w_is_lower = (rx_data >= 8'h61) && (rx_data <= 8'h7A);
   assign w_is_term  = (rx_data == 8'h0D) || (rx_data == 8'h0A);
   assign w_is_space = (rx_data == 8'h20);
   assign w_digit    = rx_data[3:0];

   // 17-bit accumulate. Above 6553 the product alone leaves 16 bits,
   // so that case is flagged directly and the 17-bit sum never wraps.
   assign w_mul = {1'b0, r_acc} * 17'd10;
   assign w_sum = w_mul + {13'd0, w_digit};
   assign w_ovf = (r_acc > 16'd6553) || w_sum[16];

   assign w_has = (r_cnt != '0);

   // Well-formed lines whose letter rejects the argument
   assign w_bad = (((r_letter == 8'h6D) || (r_letter == 8'h64))
                   && w_has && (r_acc > 16'd1))
               || ((r_letter == 8'h72) && w_has);

   assign w_done = new_rx_data && w_is_term
                && ((r_state == ARG) || (r_state == FLUSH));
   assign w_err  = (r_state == FLUSH) || w_bad;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_letter    <= 8'd0;
         r_acc       <= 16'd0;
         r_cnt       <= '0;
         cmd_valid   <= 1'b0;
         cmd_char    <= 8'd0;
         cmd_arg     <= 16'd0;
         cmd_has_arg <= 1'b0;
         cmd_err     <= 1'b0;
         motor_arm   <= 1'b0;
         data_log    <= 1'b0;
         soft_rst    <= 1'b0;
         err_cnt     <= 8'd0;
      end else begin
         cmd_valid <= 1'b0;
         soft_rst  <= 1'b0;

         if (new_rx_data) begin
            unique case (r_state)
               IDLE: begin
                  if (w_is_lower) begin
                     r_letter <= rx_data;
                     r_acc    <= 16'd0;
                     r_cnt    <= '0;
                     r_state  <= ARG;
                  end else if (!(w_is_term || w_is_space)) begin
                     // no letter on this line: report 0x00
                     r_letter <= 8'd0;
                     r_acc    <= 16'd0;
                     r_cnt    <= '0;
                     r_state  <= FLUSH;
                  end
               end
               ARG: begin
                  if (w_is_digit) begin
                     if ((r_cnt < MAXD) && !w_ovf) begin
                        r_acc <= w_sum[15:0];
                        r_cnt <= r_cnt + 1'b1;
                     end else begin
                        r_state <= FLUSH;
                     end
                  end else if (w_is_term) begin
                     r_state <= IDLE;
                  end else begin
                     r_state <= FLUSH;
                  end
               end
               FLUSH: begin
                  if (w_is_term) begin
                     r_state <= IDLE;
                  end
               end
               default: r_state <= IDLE;
            endcase
         end

         if (w_done) begin
            cmd_valid   <= 1'b1;
            cmd_char    <= r_letter;
            cmd_has_arg <= w_has;
            if (w_err) begin
               cmd_err <= 1'b1;
               cmd_arg <= 16'd0;
               if (err_cnt != 8'hFF) begin
                  err_cnt <= err_cnt + 8'd1;
               end
            end else begin
               cmd_err <= 1'b0;
               cmd_arg <= r_acc;
               if (r_letter == 8'h6D) begin
                  motor_arm <= w_has ? r_acc[0] : ~motor_arm;
               end
               if (r_letter == 8'h64) begin
                  data_log <= w_has ? r_acc[0] : ~data_log;
               end
               if (r_letter == 8'h72) begin
                  soft_rst <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_cmd_receiver.sv
// tb_cmd_receiver: scoreboard bench for cmd_receiver.
// In strings, '|' stands for CR and '~' for LF.
module tb_cmd_receiver;

   logic        clk;
   logic        rst;
   logic [7:0]  rx_data;
   logic        new_rx_data;
   logic        cmd_valid;
   logic [7:0]  cmd_char;
   logic [15:0] cmd_arg;
   logic        cmd_has_arg;
   logic        cmd_err;
   logic        motor_arm;
   logic        data_log;
   logic        soft_rst;
   logic [7:0]  err_cnt;

   cmd_receiver #(.MAX_DIGITS(5)) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_data     (rx_data),
      .new_rx_data (new_rx_data),
      .cmd_valid   (cmd_valid),
      .cmd_char    (cmd_char),
      .cmd_arg     (cmd_arg),
      .cmd_has_arg (cmd_has_arg),
      .cmd_err     (cmd_err),
      .motor_arm   (motor_arm),
      .data_log    (data_log),
      .soft_rst    (soft_rst),
      .err_cnt     (err_cnt)
   );

   typedef struct {
      logic [7:0] ch;
      int         arg;
      bit         has;
      bit         err;
      bit         mot;
      bit         dl;
      bit         sr;
      int         ec;
      int         cyc;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   exp_ec = 0;
   int   soft_seen = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   always @(negedge clk) begin
      if (soft_rst) soft_seen++;
      if (cmd_valid) begin
         if (exp_q.size() == 0) begin
            chk("spurious_valid", {31'd0, cmd_valid}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("valid_cycle", cyc, e.cyc);
            chk("cmd_char", {24'd0, cmd_char}, {24'd0, e.ch});
            chk("cmd_arg", {16'd0, cmd_arg}, e.arg);
            chk("cmd_err", {31'd0, cmd_err}, {31'd0, e.err});
            if (!e.err)
               chk("cmd_has_arg", {31'd0, cmd_has_arg}, {31'd0, e.has});
            chk("motor_arm", {31'd0, motor_arm}, {31'd0, e.mot});
            chk("data_log", {31'd0, data_log}, {31'd0, e.dl});
            chk("soft_rst", {31'd0, soft_rst}, {31'd0, e.sr});
            chk("err_cnt", {24'd0, err_cnt}, e.ec);
         end
      end
   end

   function automatic logic [7:0] map_b(input logic [7:0] c);
      if (c == 8'h7C) return 8'h0D;
      if (c == 8'h7E) return 8'h0A;
      return c;
   endfunction

   // Called at #1 after a posedge; returns at #1 after a later posedge.
   task automatic put_byte(input logic [7:0] b, input int gap);
      rx_data     = b;
      new_rx_data = 1'b1;
      @(posedge clk);
      #1;
      new_rx_data = 1'b0;
      rx_data     = 8'h0D;
      for (int g = 0; g < gap; g++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_raw(input string s);
      for (int i = 0; i < s.len(); i++) put_byte(map_b(s[i]), 0);
   endtask

   task automatic send_line(input string s, input int gap,
                            input logic [7:0] ch, input int arg,
                            input bit has, input bit err,
                            input bit mot, input bit dl, input bit sr);
      exp_t x;
      for (int i = 0; i < s.len(); i++) begin
         if (i == s.len() - 1) begin
            if (err && exp_ec < 255) exp_ec++;
            x.ch  = ch;
            x.arg = arg;
            x.has = has;
            x.err = err;
            x.mot = mot;
            x.dl  = dl;
            x.sr  = sr;
            x.ec  = exp_ec;
            x.cyc = cyc + 1;
            exp_q.push_back(x);
         end
         put_byte(map_b(s[i]), gap);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"}, {31'd0, cmd_valid}, 32'd0);
      chk({tag, "_char"}, {24'd0, cmd_char}, 32'd0);
      chk({tag, "_arg"}, {16'd0, cmd_arg}, 32'd0);
      chk({tag, "_has"}, {31'd0, cmd_has_arg}, 32'd0);
      chk({tag, "_err"}, {31'd0, cmd_err}, 32'd0);
      chk({tag, "_motor"}, {31'd0, motor_arm}, 32'd0);
      chk({tag, "_dlog"}, {31'd0, data_log}, 32'd0);
      chk({tag, "_srst"}, {31'd0, soft_rst}, 32'd0);
      chk({tag, "_errcnt"}, {24'd0, err_cnt}, 32'd0);
   endtask

   initial begin
      rst         = 1'b0;
      rx_data     = 8'd0;
      new_rx_data = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("rst0");
      rst = 1'b1;
      @(posedge clk);
      #1;

      send_line("m|", 0, 8'h6D, 0, 0, 0, 1, 0, 0);
      send_line("m|", 0, 8'h6D, 0, 0, 0, 0, 0, 0);
      send_line("x65535~", 0, 8'h78, 65535, 1, 0, 0, 0, 0);
      send_line("x65536~", 0, 8'h78, 0, 1, 1, 0, 0, 0);
      send_line("d12|", 0, 8'h64, 0, 1, 1, 0, 0, 0);
      send_line("d1|", 2, 8'h64, 1, 1, 0, 0, 1, 0);
      send_line("r|", 0, 8'h72, 0, 0, 0, 0, 1, 1);
      send_line("#m|", 0, 8'h00, 0, 0, 1, 0, 1, 0);
      send_line("x123456|", 0, 8'h78, 0, 1, 1, 0, 1, 0);
      send_line(" m1|", 0, 8'h6D, 1, 1, 0, 1, 1, 0);
      send_raw("|~ ");
      send_line("z42~", 1, 8'h7A, 42, 1, 0, 1, 1, 0);
      send_line("m7|", 0, 8'h6D, 0, 1, 1, 1, 1, 0);
      send_line("r5|", 0, 8'h72, 0, 1, 1, 1, 1, 0);
      send_line("d|", 0, 8'h64, 0, 0, 0, 1, 0, 0);
      send_line("m0|", 0, 8'h6D, 0, 1, 0, 0, 0, 0);
      send_line("m1|", 0, 8'h6D, 1, 1, 0, 1, 0, 0);

      repeat (3) @(posedge clk);
      #1;
      send_raw("m1");
      #2;
      rst = 1'b0;
      #1;
      chk_all_zero("rst_mid");
      @(posedge clk);
      #1;
      rst    = 1'b1;
      exp_ec = 0;
      @(posedge clk);
      #1;
      send_raw("|");
      repeat (3) @(posedge clk);
      #1;
      chk("after_rst_motor", {31'd0, motor_arm}, 32'd0);
      send_line("m|", 0, 8'h6D, 0, 0, 0, 1, 0, 0);

      for (int i = 0; i < 256; i++)
         send_line("#|", 0, 8'h00, 0, 0, 1, 1, 0, 0);

      repeat (5) @(posedge clk);
      #1;
      chk("queue_drained", exp_q.size(), 32'd0);
      chk("soft_rst_cycles", soft_seen, 32'd1);
      chk("err_cnt_sat", {24'd0, err_cnt}, 32'd255);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
